sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requesting channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter OUTST_DEPTH, default 4, maximum outstanding requests (power of 2).
REQ-005 SHALL have port clk  input  1  sole clock; all state rises on posedge.
REQ-006 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port ch_req  input  NUM_CH  per-channel request valid.
REQ-008 SHALL have port ch_wr  input  NUM_CH  per-channel write flag.
REQ-009 SHALL have port ch_wstrb  input  NUM_CH*DATA_W/8  packed byte strobes.
REQ-010 SHALL have port ch_addr  input  NUM_CH*ADDR_W  packed addresses.
REQ-011 SHALL have port ch_wdata  input  NUM_CH*DATA_W  packed write data.
REQ-012 SHALL have port ch_addr_ok  output  NUM_CH  request accepted, one-hot or zero.
REQ-013 SHALL have port ch_data_ok  output  NUM_CH  response returned, one-hot or zero.
REQ-014 SHALL have port ch_rdata  output  DATA_W  shared read data, valid with ch_data_ok.
REQ-015 SHALL have ports mem_req, mem_wr (output 1), mem_wstrb, mem_addr, mem_wdata (output, widths as channel), mem_addr_ok, mem_data_ok (input 1) and mem_rdata (input DATA_W): downstream sram-like port.

Function
REQ-016 SHALL select the granted channel combinationally by round-robin: first asserted ch_req at or after rr_ptr, wrapping modulo NUM_CH.
REQ-017 SHALL drive mem_req = |ch_req AND NOT id_fifo_full, with mem_wr/wstrb/addr/wdata muxed from the granted channel (all zero when no request).
REQ-018 SHALL assert ch_addr_ok[g] = mem_req AND mem_addr_ok for granted channel g only; zero-cycle latency.
REQ-019 SHALL, on an address handshake, push g into the id FIFO and set rr_ptr to (g+1) mod NUM_CH; otherwise hold rr_ptr.
REQ-020 SHALL, on mem_data_ok with non-empty FIFO, pop the head id h, assert ch_data_ok[h] in the same cycle and pass mem_rdata to ch_rdata; both reads and writes return one data_ok.
REQ-021 SHALL ignore mem_data_ok while the FIFO is empty (no pop, no ch_data_ok).
REQ-022 SHALL return responses in acceptance order across all channels.
REQ-023 SHALL, when the FIFO is full, hold mem_req low even if a pop occurs the same cycle; push and pop together when not full leave occupancy unchanged.
REQ-024 SHALL never grant a channel whose ch_req is low; a channel dropping ch_req before addr_ok loses its turn without side effects.

Reset
REQ-025 SHALL, on resetn low, asynchronously clear FIFO pointers and count, rr_ptr to 0 and any counters to 0; outputs derived from them go to zero.
REQ-026 SHALL discard outstanding ids on reset mid-operation; mem_data_ok arriving after reset with empty FIFO is ignored per REQ-021.

Configuration
REQ-027 SHALL, with SRAM_ARB_STALL_CNT_EN defined, add output stall_cnt (32 bits) incrementing each cycle where |ch_req is high and no address handshake occurs, wrapping at 2^32-1 to 0.
REQ-028 SHALL, without SRAM_ARB_STALL_CNT_EN, omit port stall_cnt and its logic entirely.

Structure
REQ-029 SHALL take default parameter values and the derived id width ($clog2(NUM_CH), minimum 1) from the shared constants.v header.
REQ-030 SHALL implement the id FIFO as sub-module sram_arb_id_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head outputs).

Verification
REQ-031 SHALL check: ch_req=2'b11, mem_addr_ok=1 constantly, rr_ptr=0 -> addr_ok grants ch0, ch1, ch0, ch1 on consecutive cycles.
REQ-032 SHALL check: ch0 read 0x1000 then ch1 write 0x2000, then mem_data_ok twice with rdata 0xDEADBEEF -> ch_data_ok=01 with rdata 0xDEADBEEF, then ch_data_ok=10.
REQ-033 SHALL check: 4 requests accepted, no data_ok -> mem_req=0 while ch_req is held; one mem_data_ok -> mem_req rises on the next cycle.
REQ-034 SHALL check: mem_data_ok pulse with empty FIFO -> ch_data_ok=0, FIFO count stays 0.
REQ-035 SHALL check: resetn low for one cycle with 3 outstanding ids -> FIFO empty and rr_ptr=0 immediately; with SRAM_ARB_STALL_CNT_EN, stall_cnt=0.
REQ-036 SHALL check: with SRAM_ARB_STALL_CNT_EN, ch_req=01 and mem_addr_ok=0 for 5 cycles -> stall_cnt=5.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: default parameters and id-width helper.
// Imported by the interface, the id FIFO and the arbiter top.
package sram_arbiter_pkg;

   localparam int unsigned NumChDef      = 2;
   localparam int unsigned AddrWDef      = 32;
   localparam int unsigned DataWDef      = 32;
   localparam int unsigned OutstDepthDef = 4;

   typedef logic [31:0] stall_cnt_t;

   // Index width for n entries, never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Channel-side and memory-side signals of the SRAM arbiter.
// master: arbiter view; slave: view of the channels plus the downstream memory.
interface sram_arbiter_if
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CH = NumChDef,
   parameter int unsigned ADDR_W = AddrWDef,
   parameter int unsigned DATA_W = DataWDef
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [NUM_CH-1:0]        ch_req;
   logic [NUM_CH-1:0]        ch_wr;
   logic [NUM_CH*STRB_W-1:0] ch_wstrb;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*DATA_W-1:0] ch_wdata;
   logic [NUM_CH-1:0]        ch_addr_ok;
   logic [NUM_CH-1:0]        ch_data_ok;
   logic [DATA_W-1:0]        ch_rdata;

   logic                     mem_req;
   logic                     mem_wr;
   logic [STRB_W-1:0]        mem_wstrb;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic                     mem_addr_ok;
   logic                     mem_data_ok;
   logic [DATA_W-1:0]        mem_rdata;

   modport master (
      input  ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      output ch_addr_ok, ch_data_ok, ch_rdata,
      output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
   );

   modport slave (
      output ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      input  ch_addr_ok, ch_data_ok, ch_rdata,
      input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
   );

endinterface

// File: rtl/sram_arb_id_fifo.sv
// Small FIFO of granted channel ids; head is the channel owed the next response.
// Push when full and pop when empty are ignored.
module sram_arb_id_fifo
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = OutstDepthDef
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int unsigned PTR_W = id_width(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted in.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter merging NUM_CH sram-like channels onto one memory port,
// returning responses in acceptance order. Optional stall counter: SRAM_ARB_STALL_CNT_EN.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CH      = NumChDef,
   parameter int unsigned ADDR_W      = AddrWDef,
   parameter int unsigned DATA_W      = DataWDef,
   parameter int unsigned OUTST_DEPTH = OutstDepthDef
) (
   input  logic           clk,
   input  logic           resetn,
   sram_arbiter_if.master bus
`ifdef SRAM_ARB_STALL_CNT_EN
   ,
   output stall_cnt_t     stall_cnt
`endif
);
   localparam int unsigned ID_W   = id_width(NUM_CH);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] grant_id, head_id;
   logic            grant_valid, any_req, mem_req;
   logic            fifo_full, fifo_empty, addr_hs, resp_pop;

   // First requester at or after rr_ptr; scanning backwards lets the nearest win.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      for (int off = int'(NUM_CH) - 1; off >= 0; off--) begin
         if (bus.ch_req[(int'(rr_ptr_q) + off) % int'(NUM_CH)]) begin
            grant_valid = 1'b1;
            grant_id    = ID_W'((int'(rr_ptr_q) + off) % int'(NUM_CH));
         end
      end
   end

   assign any_req  = |bus.ch_req;
   assign mem_req  = any_req & ~fifo_full;
   assign addr_hs  = mem_req & bus.mem_addr_ok;
   assign resp_pop = bus.mem_data_ok & ~fifo_empty;

   assign bus.mem_req   = mem_req;
   assign bus.mem_wr    = grant_valid & bus.ch_wr[grant_id];
   assign bus.mem_wstrb = grant_valid ? bus.ch_wstrb[grant_id*STRB_W +: STRB_W] : '0;
   assign bus.mem_addr  = grant_valid ? bus.ch_addr[grant_id*ADDR_W +: ADDR_W] : '0;
   assign bus.mem_wdata = grant_valid ? bus.ch_wdata[grant_id*DATA_W +: DATA_W] : '0;

   assign bus.ch_addr_ok = addr_hs ? (NUM_CH'(1) << grant_id) : '0;
   assign bus.ch_data_ok = resp_pop ? (NUM_CH'(1) << head_id) : '0;
   assign bus.ch_rdata   = bus.mem_rdata;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (addr_hs) begin
         rr_ptr_d = (grant_id == ID_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rr_ptr_q <= '0;
      else         rr_ptr_q <= rr_ptr_d;
   end

   sram_arb_id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (OUTST_DEPTH)
   ) u_id_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (addr_hs),
      .push_data (grant_id),
      .pop       (resp_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head_id)
   );

`ifdef SRAM_ARB_STALL_CNT_EN
   stall_cnt_t stall_q;

   // Cycles where someone wanted the port but no request was accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                 stall_q <= '0;
      else if (any_req && !addr_hs) stall_q <= stall_q + 1'b1;
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of grant order, outstanding ids and stall count.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   localparam int unsigned NCH   = 2;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   sram_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SRAM_ARB_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   sram_arbiter #(
      .NUM_CH      (NCH),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .OUTST_DEPTH (DEPTH)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
`ifdef SRAM_ARB_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int          q[$];
   int          rr;
   logic [31:0] stall_m;
   bit          pend_hs, pend_pop, pend_stall;
   int          pend_g;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      rr      = 0;
      stall_m = '0;
   endtask

   task automatic drive_ch(input int c, input bit req, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
      bus.ch_req[c]             = req;
      bus.ch_wr[c]              = wr;
      bus.ch_addr[c*AW +: AW]   = addr;
      bus.ch_wdata[c*DW +: DW]  = wdata;
      bus.ch_wstrb[c*SW +: SW]  = wstrb;
   endtask

   task automatic drive_mem(input bit aok, input bit dok, input logic [31:0] rdata);
      bus.mem_addr_ok = aok;
      bus.mem_data_ok = dok;
      bus.mem_rdata   = rdata;
   endtask

   // Settle combinational outputs, compare everything against the model.
   task automatic eval();
      bit          any, full, mreq;
      int          g;
      logic [63:0] exp_aok, exp_dok;
      #1;
      any = (bus.ch_req != '0);
      g   = -1;
      for (int off = 0; off < int'(NCH); off++) begin
         if (g < 0 && bus.ch_req[(rr + off) % int'(NCH)]) g = (rr + off) % int'(NCH);
      end
      full = (q.size() >= int'(DEPTH));
      mreq = any && !full;
      check("mem_req", 64'(bus.mem_req), 64'(mreq));
      if (any) begin
         check("mem_addr", 64'(bus.mem_addr), 64'(bus.ch_addr[g*AW +: AW]));
         check("mem_wdata", 64'(bus.mem_wdata), 64'(bus.ch_wdata[g*DW +: DW]));
         check("mem_ctl", 64'({bus.mem_wr, bus.mem_wstrb}),
               64'({bus.ch_wr[g], bus.ch_wstrb[g*SW +: SW]}));
      end else begin
         check("mem_idle", 64'({bus.mem_wr, bus.mem_wstrb, bus.mem_addr}), 64'(0));
         check("mem_idle_wdata", 64'(bus.mem_wdata), 64'(0));
      end
      pend_hs    = mreq && bus.mem_addr_ok;
      pend_g     = g;
      pend_stall = any && !pend_hs;
      exp_aok    = pend_hs ? (64'(1) << g) : 64'(0);
      check("ch_addr_ok", 64'(bus.ch_addr_ok), exp_aok);
      pend_pop = bus.mem_data_ok && (q.size() > 0);
      exp_dok  = pend_pop ? (64'(1) << q[0]) : 64'(0);
      check("ch_data_ok", 64'(bus.ch_data_ok), exp_dok);
      if (pend_pop) check("ch_rdata", 64'(bus.ch_rdata), 64'(bus.mem_rdata));
`ifdef SRAM_ARB_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
   endtask

   // Clock edge: retire what eval() predicted, then step off the edge.
   task automatic advance();
      @(posedge clk);
      if (pend_pop) void'(q.pop_front());
      if (pend_hs) begin
         q.push_back(pend_g);
         rr = (pend_g + 1) % int'(NCH);
      end
      if (pend_stall) stall_m = stall_m + 32'd1;
      #1;
   endtask

   task automatic do_reset();
      resetn       = 1'b0;
      bus.ch_req   = '0;
      bus.ch_wr    = '0;
      bus.ch_addr  = '0;
      bus.ch_wdata = '0;
      bus.ch_wstrb = '0;
      drive_mem(1'b0, 1'b0, 32'h0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      do_reset();

      // Reset state: idle port, nothing returned.
      eval();
      check("reset_mem_req", 64'(bus.mem_req), 64'(0));
      advance();

      // Alternating grants with both channels requesting, then FIFO full.
      drive_ch(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      drive_ch(1, 1'b1, 1'b1, 32'h200, 32'h55, 4'hf);
      drive_mem(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         eval();
         check("rr_seq", 64'(bus.ch_addr_ok), (i % 2 == 0) ? 64'h1 : 64'h2);
         advance();
      end
      for (int i = 0; i < 2; i++) begin
         eval();
         check("full_hold", 64'(bus.mem_req), 64'(0));
         advance();
      end
      drive_mem(1'b1, 1'b1, 32'h1234);
      eval();
      check("full_pop_req", 64'(bus.mem_req), 64'(0));
      check("full_pop_dok", 64'(bus.ch_data_ok), 64'h1);
      advance();
      drive_mem(1'b1, 1'b0, 32'h0);
      eval();
      check("full_release", 64'(bus.mem_req), 64'(1));
      advance();

      // Ordered read then write responses.
      do_reset();
      drive_ch(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
      drive_mem(1'b1, 1'b0, 32'h0);
      eval();
      check("rd_addr", 64'(bus.mem_addr), 64'h1000);
      advance();
      drive_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive_ch(1, 1'b1, 1'b1, 32'h2000, 32'hcafe, 4'hf);
      eval();
      check("wr_ok", 64'({bus.mem_wr, bus.ch_addr_ok}), 64'({1'b1, 2'b10}));
      advance();
      drive_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive_mem(1'b0, 1'b1, 32'hdeadbeef);
      eval();
      check("resp0", 64'({bus.ch_data_ok, bus.ch_rdata}), 64'({2'b01, 32'hdeadbeef}));
      advance();
      eval();
      check("resp1", 64'(bus.ch_data_ok), 64'h2);
      advance();

      // data_ok with nothing outstanding is dropped.
      for (int i = 0; i < 2; i++) begin
         eval();
         check("empty_dok", 64'(bus.ch_data_ok), 64'(0));
         advance();
      end

      // Reset with three ids outstanding.
      do_reset();
      drive_ch(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      drive_ch(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      drive_mem(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         eval();
         advance();
      end
      resetn = 1'b0;
      model_clear();
      drive_mem(1'b1, 1'b1, 32'h77);
      eval();
      check("rst_grant", 64'(bus.ch_addr_ok), 64'h1);
      check("rst_dok", 64'(bus.ch_data_ok), 64'(0));
`ifdef SRAM_ARB_STALL_CNT_EN
      check("rst_stall", 64'(stall_cnt), 64'(0));
`endif
      @(posedge clk);
      #1;
      resetn = 1'b1;
      bus.ch_req = '0;
      eval();
      check("post_rst_dok", 64'(bus.ch_data_ok), 64'(0));
      advance();

`ifdef SRAM_ARB_STALL_CNT_EN
      do_reset();
      drive_ch(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      drive_mem(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         eval();
         advance();
      end
      eval();
      check("stall_five", 64'(stall_cnt), 64'd5);
      advance();
`endif

      // Random traffic.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < int'(NCH); c++) begin
            drive_ch(c, ($urandom_range(0, 9) < 6), 1'($urandom), $urandom, $urandom,
                     4'($urandom));
         end
         drive_mem(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom);
         eval();
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
